// File: rtl/div4_sched_pkg.sv
// Shared types and helpers for the div4 request scheduler.
package div4_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned MIN_WIDTH = 3;

  // Requester id width; a single-bit id is kept even for tiny requester counts.
  function automatic int unsigned id_w(input int unsigned num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/div4.sv
// Divide-by-four datapath: drops the two LSBs when enabled.
module div4 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-3:0] data_o
);

  logic unused_lsb;

  assign unused_lsb = ^data_i[1:0];
  assign data_o     = en_i ? data_i[WIDTH-1:2] : '0;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after the pointer wins.
module rr_arbiter
  import div4_sched_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 3,
  localparam int unsigned ID_W    = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    idx_o
);

  int unsigned k;

  // Scan from the farthest offset down so the nearest valid requester wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    k       = 0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      k = 32'(ptr_i) + 32'(i);
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (req_i[k]) begin
        grant_o    = '0;
        grant_o[k] = 1'b1;
        idx_o      = ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/div4_sched.sv
// Round-robin scheduler sharing one div4 datapath; each request is divided by 4 per pass.
module div4_sched
  import div4_sched_pkg::*;
#(
  parameter  int unsigned WIDTH   = 8,
  parameter  int unsigned NUM_REQ = 3,
  parameter  int unsigned PASS_W  = 2,
  localparam int unsigned ID_W    = id_w(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0]  req_data_i,
  input  logic [NUM_REQ*PASS_W-1:0] req_passes_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      rsp_valid_o,
  output logic [WIDTH-1:0]          rsp_data_o,
  output logic [ID_W-1:0]           rsp_id_o,
  input  logic                      rsp_ready_i,
  output logic                      busy_o
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [PASS_W-1:0] cnt_q, cnt_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [ID_W-1:0]    arb_idx;
  logic [WIDTH-1:0]   sel_data;
  logic [PASS_W-1:0]  sel_passes;
  logic               div_en;
  logic [WIDTH-3:0]   div_out;
  logic               accept;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx)
  );

  div4 #(.WIDTH(WIDTH)) u_div4 (
    .en_i   (div_en),
    .data_i (acc_q),
    .data_o (div_out)
  );

  // Grant is only visible while idle and out of reset.
  assign req_ready_o = arb_grant & {NUM_REQ{(state_q == IDLE) && rst_ni}};
  assign accept      = |(req_ready_o & req_valid_i);
  assign sel_data    = req_data_i[32'(arb_idx)*WIDTH +: WIDTH];
  assign sel_passes  = req_passes_i[32'(arb_idx)*PASS_W +: PASS_W];
  assign div_en      = (state_q == RUN);

  assign rsp_valid_o = (state_q == DONE);
  assign rsp_data_o  = (state_q == DONE) ? acc_q : '0;
  assign rsp_id_o    = (state_q == DONE) ? id_q : '0;
  assign busy_o      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = sel_data;
          cnt_d   = sel_passes;
          id_d    = arb_idx;
          ptr_d   = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
          state_d = (sel_passes != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        acc_d = {2'b00, div_out};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == PASS_W'(1)) state_d = DONE;
      end
      DONE: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_div4_sched.sv
// Scoreboard bench for div4_sched with a cycle-level arbiter/latency model.
module tb_div4_sched;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned PASS_W  = 2;
  localparam int unsigned ID_W    = 2;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               id;
  } exp_t;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*WIDTH-1:0]  req_data;
  logic [NUM_REQ*PASS_W-1:0] req_passes;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rsp_valid;
  logic [WIDTH-1:0]          rsp_data;
  logic [ID_W-1:0]           rsp_id;
  logic                      rsp_ready;
  logic                      busy;

  int   n_vec;
  int   n_err;
  int   cyc;
  exp_t sb[$];
  int   glog[$];
  int   mptr;
  bit   m_busy;
  int   done_cyc;
  logic [WIDTH-1:0] last_data;
  int   last_id;

  div4_sched #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .PASS_W(PASS_W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_passes_i (req_passes),
    .req_ready_o  (req_ready),
    .rsp_valid_o  (rsp_valid),
    .rsp_data_o   (rsp_data),
    .rsp_id_o     (rsp_id),
    .rsp_ready_i  (rsp_ready),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: round-robin winner, response timing and result value.
  always @(negedge clk) begin
    int w;
    int act;
    int p;
    logic [NUM_REQ-1:0] exp_rdy;
    bit exp_rv;
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      m_busy = 1'b0;
      mptr   = 0;
    end else begin
      w = -1;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        int k;
        k = (mptr + i) % int'(NUM_REQ);
        if (w < 0 && req_valid[k]) w = k;
      end
      exp_rdy = '0;
      if (!m_busy && w >= 0) exp_rdy[w] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(m_busy));
      exp_rv = m_busy && (cyc >= done_cyc);
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      if (exp_rv && sb.size() > 0) begin
        chk("rsp_data", 32'(rsp_data), 32'(sb[0].data));
        chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
        if (rsp_ready) begin
          last_data = sb[0].data;
          last_id   = sb[0].id;
          void'(sb.pop_front());
          m_busy = 1'b0;
        end
      end else if (!m_busy && w >= 0) begin
        act = -1;
        for (int i = 0; i < int'(NUM_REQ); i++) if (req_ready[i]) act = i;
        glog.push_back(act);
        p      = int'(req_passes[w*PASS_W +: PASS_W]);
        e.data = req_data[w*WIDTH +: WIDTH] >> (2 * p);
        e.id   = w;
        sb.push_back(e);
        m_busy   = 1'b1;
        done_cyc = cyc + p + 1;
        mptr     = (w + 1) % int'(NUM_REQ);
      end
    end
  end

  task automatic send(input int k, input logic [WIDTH-1:0] d, input logic [PASS_W-1:0] p);
    bit got;
    got = 1'b0;
    req_valid[k] = 1'b1;
    req_data[k*WIDTH +: WIDTH]    = d;
    req_passes[k*PASS_W +: PASS_W] = p;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (req_ready[k]) got = 1'b1;
    end
    if (!got) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1 req_valid[k] = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(posedge clk);
      #1 if (sb.size() == 0 && !m_busy) ok = 1'b1;
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  task automatic wait_grants(input int num);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(posedge clk);
      #1 if (glog.size() >= num) ok = 1'b1;
    end
    if (!ok) chk("grant_timeout", 0, 1);
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    mptr = 0; m_busy = 1'b0; done_cyc = 0;
    last_data = '0; last_id = -1;
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '1;
    req_data = '0;
    req_passes = '0;

    // Outputs held at zero in reset even with requests pending
    #2;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_busy", 32'(busy), 0);
    #10 req_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    send(0, 8'hC8, 2'd1); wait_idle();
    chk("t1_data", 32'(last_data), 32'h32); chk("t1_id", last_id, 0);
    send(1, 8'hFF, 2'd3); wait_idle();
    chk("t2_data", 32'(last_data), 32'h03); chk("t2_id", last_id, 1);
    send(2, 8'hA5, 2'd0); wait_idle();
    chk("t3_data", 32'(last_data), 32'hA5); chk("t3_id", last_id, 2);

    // All requesters valid continuously
    glog.delete();
    req_data   = {8'h90, 8'h60, 8'h30};
    req_passes = {2'd1, 2'd1, 2'd1};
    req_valid  = '1;
    wait_grants(5);
    req_valid = '0;
    wait_idle();
    for (int i = 0; i < 5; i++) chk("rr_order", glog[i], i % 3);

    // Consumer stall in DONE with another requester waiting
    rsp_ready = 1'b0;
    send(0, 8'h5A, 2'd2);
    req_valid[1] = 1'b1;
    req_data[WIDTH +: WIDTH] = 8'h3C;
    req_passes[PASS_W +: PASS_W] = 2'd0;
    for (int n = 0; n < 50 && !rsp_valid; n++) @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("stall_ready", 32'(req_ready), 0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    glog.delete();
    wait_grants(1);
    req_valid[1] = 1'b0;
    chk("stall_next", glog[0], 1);
    wait_idle();

    // Reset mid-RUN drops the request and restarts the pointer
    send(1, 8'hF0, 2'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 0);
    chk("mid_rst_valid", 32'(rsp_valid), 0);
    chk("mid_rst_data", 32'(rsp_data), 0);
    chk("mid_rst_id", 32'(rsp_id), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    glog.delete();
    req_passes = {2'd1, 2'd2, 2'd1};
    req_valid  = '1;
    wait_grants(1);
    req_valid = '0;
    chk("post_rst_grant", glog[0], 0);
    wait_idle();

    // Lone requester 2 twice: search wraps past the pointer
    glog.delete();
    send(2, 8'h81, 2'd1);
    send(2, 8'h40, 2'd2);
    wait_idle();
    chk("wrap_g0", glog[0], 2);
    chk("wrap_g1", glog[1], 2);

    // Random requests with occasional consumer back-pressure
    for (int r = 0; r < 200; r++) begin
      send(int'($urandom_range(0, NUM_REQ - 1)), WIDTH'($urandom), PASS_W'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        rsp_ready = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 rsp_ready = 1'b1;
      end
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
